// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared types and constants for the EX-stage forwarding / load-use hazard controller.
// Select codes match the EX operand mux input order.
package fwd_hazard_ctrl_pkg;

  localparam int REG_BITS = 3;
  localparam logic [REG_BITS-1:0] ZERO_REG = '0;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_WB      = 2'b01;
  localparam logic [1:0] FWD_MEM     = 2'b10;

  typedef logic [REG_BITS-1:0] reg_idx_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t rs;
    reg_idx_t rt;
    logic     uses_rs;
    logic     uses_rt;
    reg_idx_t dest;
    logic     reg_write;
    logic     mem_read;
  } ex_rec_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t dest;
    logic     reg_write;
  } wr_rec_t;

  // r0 is hardwired, so a writer targeting it never produces anything worth forwarding.
  function automatic logic writes_reg(input wr_rec_t w, input reg_idx_t r);
    return w.valid && w.reg_write && (w.dest == r) && (r != ZERO_REG);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic en);
    return (en && (c != 16'hFFFF)) ? c + 16'd1 : c;
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_fwd_select.sv
// Priority compare for one EX operand: newest non-load writer in EX wins, then the MEM writer,
// otherwise the register file value is used.
module fwd_select
  import fwd_hazard_ctrl_pkg::*;
(
  input  logic       in_valid,
  input  reg_idx_t   src,
  input  logic       uses_src,
  input  wr_rec_t    ex_wr,
  input  logic       ex_is_load,
  input  wr_rec_t    mem_wr,
  output logic [1:0] code
);

  always_comb begin
    code = FWD_REGFILE;
    if (in_valid && uses_src) begin
      if (writes_reg(ex_wr, src) && !ex_is_load) begin
        code = FWD_MEM;
      end else if (writes_reg(mem_wr, src)) begin
        code = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Tracks EX/MEM/WB writers beside ID/EX, registers ForwardA/B and raises the load-use Stall.
// Define FWD_STATS_EN to add saturating StallCount/FwdMemCount/FwdWbCount outputs.
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                ID_Valid,
  input  logic [REG_BITS-1:0] ID_Rs,
  input  logic [REG_BITS-1:0] ID_Rt,
  input  logic                ID_UsesRs,
  input  logic                ID_UsesRt,
  input  logic [REG_BITS-1:0] ID_DestReg,
  input  logic                ID_RegWrite,
  input  logic                ID_MemRead,
  input  logic                Flush,
  output logic [1:0]          ForwardA,
  output logic [1:0]          ForwardB,
  output logic                Stall
`ifdef FWD_STATS_EN
  ,
  output logic [15:0]         StallCount,
  output logic [15:0]         FwdMemCount,
  output logic [15:0]         FwdWbCount
`endif
);

  ex_rec_t    ex_q, ex_d;
  wr_rec_t    mem_q, mem_d;
  wr_rec_t    wb_q, wb_d;
  logic [1:0] fwd_a_q, fwd_a_d;
  logic [1:0] fwd_b_q, fwd_b_d;
  wr_rec_t    ex_wr;
  logic       stall;
  logic       issue;
  logic       unused_rec;

  assign ex_wr = '{valid: ex_q.valid, dest: ex_q.dest, reg_write: ex_q.reg_write};

  // Source fields and WB record are carried for pipeline visibility only.
  assign unused_rec = ^{wb_q, ex_q.rs, ex_q.rt, ex_q.uses_rs, ex_q.uses_rt};

  always_comb begin
    stall = ID_Valid && !Flush && ex_q.mem_read &&
            ((ID_UsesRs && writes_reg(ex_wr, ID_Rs)) ||
             (ID_UsesRt && writes_reg(ex_wr, ID_Rt)));
    issue = ID_Valid && !Flush && !stall;
  end

  always_comb begin
    mem_d = ex_wr;
    wb_d  = mem_q;
    ex_d  = '0;
    if (issue) begin
      ex_d = '{valid: 1'b1, rs: ID_Rs, rt: ID_Rt, uses_rs: ID_UsesRs, uses_rt: ID_UsesRt,
               dest: ID_DestReg, reg_write: ID_RegWrite, mem_read: ID_MemRead};
    end
  end

  fwd_select u_sel_a (
    .in_valid   (issue),
    .src        (ID_Rs),
    .uses_src   (ID_UsesRs),
    .ex_wr      (ex_wr),
    .ex_is_load (ex_q.mem_read),
    .mem_wr     (mem_q),
    .code       (fwd_a_d)
  );

  fwd_select u_sel_b (
    .in_valid   (issue),
    .src        (ID_Rt),
    .uses_src   (ID_UsesRt),
    .ex_wr      (ex_wr),
    .ex_is_load (ex_q.mem_read),
    .mem_wr     (mem_q),
    .code       (fwd_b_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      fwd_a_q <= FWD_REGFILE;
      fwd_b_q <= FWD_REGFILE;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign ForwardA = fwd_a_q;
  assign ForwardB = fwd_b_q;
  assign Stall    = stall;

`ifdef FWD_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] mem_cnt_q, mem_cnt_d;
  logic [15:0] wb_cnt_q, wb_cnt_d;

  // Both operands selecting the same source in one cycle count once.
  always_comb begin
    stall_cnt_d = sat_inc(stall_cnt_q, stall);
    mem_cnt_d   = sat_inc(mem_cnt_q, (fwd_a_d == FWD_MEM) || (fwd_b_d == FWD_MEM));
    wb_cnt_d    = sat_inc(wb_cnt_q, (fwd_a_d == FWD_WB) || (fwd_b_d == FWD_WB));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      mem_cnt_q   <= '0;
      wb_cnt_q    <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      mem_cnt_q   <= mem_cnt_d;
      wb_cnt_q    <= wb_cnt_d;
    end
  end

  assign StallCount  = stall_cnt_q;
  assign FwdMemCount = mem_cnt_q;
  assign FwdWbCount  = wb_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed table + randomized checks of fwd_hazard_ctrl against a dependency-distance model.
module tb_fwd_hazard_ctrl;

  typedef struct {
    logic       valid;
    logic [2:0] rs;
    logic [2:0] rt;
    logic       urs;
    logic       urt;
    logic [2:0] dest;
    logic       rw;
    logic       mr;
    logic       fl;
    logic       st;
    logic [1:0] fa;
    logic [1:0] fb;
  } vec_t;

  typedef struct {
    bit valid;
    int dest;
    bit rw;
    bit load;
  } wr_t;

  logic       clk;
  logic       rst;
  logic       ID_Valid;
  logic [2:0] ID_Rs;
  logic [2:0] ID_Rt;
  logic       ID_UsesRs;
  logic       ID_UsesRt;
  logic [2:0] ID_DestReg;
  logic       ID_RegWrite;
  logic       ID_MemRead;
  logic       Flush;
  logic [1:0] ForwardA;
  logic [1:0] ForwardB;
  logic       Stall;
`ifdef FWD_STATS_EN
  logic [15:0] StallCount;
  logic [15:0] FwdMemCount;
  logic [15:0] FwdWbCount;
`endif

  int vectors = 0;
  int miscompares = 0;
  wr_t hist[$];
  int m_stall_cnt = 0;
  int m_mem_cnt = 0;
  int m_wb_cnt = 0;
  vec_t tbl[30];

  fwd_hazard_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .ID_Valid    (ID_Valid),
    .ID_Rs       (ID_Rs),
    .ID_Rt       (ID_Rt),
    .ID_UsesRs   (ID_UsesRs),
    .ID_UsesRt   (ID_UsesRt),
    .ID_DestReg  (ID_DestReg),
    .ID_RegWrite (ID_RegWrite),
    .ID_MemRead  (ID_MemRead),
    .Flush       (Flush),
    .ForwardA    (ForwardA),
    .ForwardB    (ForwardB),
    .Stall       (Stall)
`ifdef FWD_STATS_EN
    ,
    .StallCount  (StallCount),
    .FwdMemCount (FwdMemCount),
    .FwdWbCount  (FwdWbCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic v, input logic [2:0] rs, input logic [2:0] rt,
                              input logic urs, input logic urt, input logic [2:0] d,
                              input logic rw, input logic mr, input logic fl,
                              input logic st, input logic [1:0] fa, input logic [1:0] fb);
    vec_t r;
    r = '{valid: v, rs: rs, rt: rt, urs: urs, urt: urt, dest: d, rw: rw, mr: mr, fl: fl,
          st: st, fa: fa, fb: fb};
    return r;
  endfunction

  function automatic vec_t nop();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0);
  endfunction

  // Model: hist[0] is the instruction one ahead of ID (now in EX), hist[1] two ahead (in MEM).
  function automatic bit writes(input wr_t w, input int r);
    return w.valid && w.rw && (w.dest == r) && (r != 0);
  endfunction

  function automatic bit model_stall(input vec_t v);
    if (!v.valid || v.fl || !hist[0].load) return 1'b0;
    return (v.urs && writes(hist[0], int'(v.rs))) || (v.urt && writes(hist[0], int'(v.rt)));
  endfunction

  function automatic logic [1:0] model_fwd(input bit issued, input int src, input bit uses);
    if (!issued || !uses) return 2'd0;
    if (writes(hist[0], src) && !hist[0].load) return 2'd2;
    if (writes(hist[1], src)) return 2'd1;
    return 2'd0;
  endfunction

  function automatic void model_reset();
    wr_t b;
    b = '{valid: 0, dest: 0, rw: 0, load: 0};
    hist = {};
    hist.push_back(b);
    hist.push_back(b);
    m_stall_cnt = 0;
    m_mem_cnt = 0;
    m_wb_cnt = 0;
  endfunction

  task automatic checkOutput(input string name, input logic [1:0] got, input logic [1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input bit use_model, input string tag);
    logic       exp_st;
    logic [1:0] exp_fa, exp_fb;
    logic [1:0] mdl_fa, mdl_fb;
    bit         mdl_st, issued;
    wr_t        w;
    ID_Valid    = v.valid;
    ID_Rs       = v.rs;
    ID_Rt       = v.rt;
    ID_UsesRs   = v.urs;
    ID_UsesRt   = v.urt;
    ID_DestReg  = v.dest;
    ID_RegWrite = v.rw;
    ID_MemRead  = v.mr;
    Flush       = v.fl;
    #1;
    mdl_st = model_stall(v);
    issued = v.valid && !v.fl && !mdl_st;
    mdl_fa = model_fwd(issued, int'(v.rs), v.urs);
    mdl_fb = model_fwd(issued, int'(v.rt), v.urt);
    exp_st = use_model ? mdl_st : v.st;
    exp_fa = use_model ? mdl_fa : v.fa;
    exp_fb = use_model ? mdl_fb : v.fb;
    checkOutput({tag, ".stall"}, {1'b0, Stall}, {1'b0, exp_st});
    @(posedge clk);
    w = '{valid: issued, dest: int'(v.dest), rw: v.rw, load: v.mr};
    if (!issued) w = '{valid: 0, dest: 0, rw: 0, load: 0};
    hist.push_front(w);
    void'(hist.pop_back());
    if (mdl_st && m_stall_cnt < 65535) m_stall_cnt++;
    if ((mdl_fa == 2'd2 || mdl_fb == 2'd2) && m_mem_cnt < 65535) m_mem_cnt++;
    if ((mdl_fa == 2'd1 || mdl_fb == 2'd1) && m_wb_cnt < 65535) m_wb_cnt++;
    #1;
    checkOutput({tag, ".fwdA"}, ForwardA, exp_fa);
    checkOutput({tag, ".fwdB"}, ForwardB, exp_fb);
  endtask

  initial begin
    vec_t v;
    // args: valid rs rt urs urt dest rw mr flush | stall fa fb
    tbl[0]  = mk(1, 1, 0, 1, 0, 2, 1, 0, 0, 0, 2'd0, 2'd0);
    tbl[1]  = mk(1, 2, 4, 1, 1, 3, 1, 0, 0, 0, 2'd2, 2'd0);
    tbl[2]  = nop();
    tbl[3]  = nop();
    tbl[4]  = mk(1, 1, 0, 1, 0, 2, 1, 0, 0, 0, 2'd0, 2'd0);
    tbl[5]  = nop();
    tbl[6]  = mk(1, 5, 2, 1, 1, 6, 1, 0, 0, 0, 2'd0, 2'd1);
    tbl[7]  = nop();
    tbl[8]  = nop();
    tbl[9]  = mk(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 2'd0, 2'd0);
    tbl[10] = mk(1, 5, 1, 1, 1, 7, 1, 0, 0, 1, 2'd0, 2'd0);
    tbl[11] = mk(1, 5, 1, 1, 1, 7, 1, 0, 0, 0, 2'd1, 2'd0);
    tbl[12] = nop();
    tbl[13] = nop();
    tbl[14] = mk(1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0);
    tbl[15] = mk(1, 0, 0, 1, 1, 1, 1, 0, 0, 0, 2'd0, 2'd0);
    tbl[16] = nop();
    tbl[17] = nop();
    tbl[18] = mk(1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 2'd0, 2'd0);
    tbl[19] = mk(1, 0, 0, 1, 1, 1, 1, 0, 0, 0, 2'd0, 2'd0);
    tbl[20] = nop();
    tbl[21] = nop();
    tbl[22] = mk(1, 1, 0, 1, 0, 3, 1, 0, 0, 0, 2'd0, 2'd0);
    tbl[23] = mk(1, 1, 0, 1, 0, 3, 1, 0, 0, 0, 2'd0, 2'd0);
    tbl[24] = mk(1, 3, 3, 1, 1, 4, 1, 0, 0, 0, 2'd2, 2'd2);
    tbl[25] = nop();
    tbl[26] = nop();
    tbl[27] = mk(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 2'd0, 2'd0);
    tbl[28] = mk(1, 5, 5, 1, 1, 6, 1, 0, 1, 0, 2'd0, 2'd0);
    tbl[29] = nop();

    rst = 1'b1;
    v = nop();
    ID_Valid = 0; ID_Rs = 0; ID_Rt = 0; ID_UsesRs = 0; ID_UsesRt = 0;
    ID_DestReg = 0; ID_RegWrite = 0; ID_MemRead = 0; Flush = 0;
    model_reset();
    #12;
    checkOutput("reset.fwdA", ForwardA, 2'd0);
    checkOutput("reset.fwdB", ForwardB, 2'd0);
    checkOutput("reset.stall", {1'b0, Stall}, 2'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 30; i++) begin
      applyStimulus(tbl[i], 1'b0, $sformatf("tbl%0d", i));
    end

    for (int i = 0; i < 500; i++) begin
      bit wide;
      wide = ($urandom_range(0, 1) == 1);
      v = nop();
      v.valid = ($urandom_range(0, 99) < 85);
      v.rs    = wide ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
      v.rt    = wide ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
      v.dest  = wide ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
      v.urs   = ($urandom_range(0, 99) < 80);
      v.urt   = ($urandom_range(0, 99) < 60);
      v.rw    = ($urandom_range(0, 99) < 75);
      v.mr    = ($urandom_range(0, 99) < 30);
      v.fl    = ($urandom_range(0, 99) < 10);
      applyStimulus(v, 1'b1, $sformatf("rnd%0d", i));
    end

    // Build a live forward, then reset between edges: it must vanish at once and stay forgotten.
    applyStimulus(nop(), 1'b0, "pre0");
    applyStimulus(nop(), 1'b0, "pre1");
    applyStimulus(mk(1, 1, 0, 1, 0, 2, 1, 0, 0, 0, 2'd0, 2'd0), 1'b0, "prod");
    applyStimulus(mk(1, 2, 4, 1, 0, 3, 1, 0, 0, 0, 2'd2, 2'd0), 1'b0, "cons");
    rst = 1'b1;
    #1;
    checkOutput("midrst.fwdA", ForwardA, 2'd0);
    checkOutput("midrst.fwdB", ForwardB, 2'd0);
    model_reset();
    #1;
    rst = 1'b0;
    applyStimulus(mk(1, 2, 3, 1, 1, 4, 1, 0, 0, 0, 2'd0, 2'd0), 1'b0, "postrst");
    applyStimulus(mk(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 2'd0, 2'd0), 1'b0, "postld");
    applyStimulus(mk(1, 5, 2, 1, 1, 6, 1, 0, 0, 1, 2'd0, 2'd0), 1'b0, "postuse");

`ifdef FWD_STATS_EN
    checkOutput("stallCount", StallCount[1:0], 2'(m_stall_cnt));
    vectors++;
    if (StallCount !== 16'(m_stall_cnt) || FwdMemCount !== 16'(m_mem_cnt) ||
        FwdWbCount !== 16'(m_wb_cnt)) begin
      miscompares++;
      $display("[TB] FAIL stats: got %0d/%0d/%0d, expected %0d/%0d/%0d",
               StallCount, FwdMemCount, FwdWbCount, m_stall_cnt, m_mem_cnt, m_wb_cnt);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
